// File: rtl/alu_op_issuer.sv
// Issues one-hot ALU requests to a combinational ALU; ALU_OP_ISSUER_ERR_EN rejects non-one-hot ops.
// Latency: response valid at the third edge after acceptance (first edge for rejected ops).
// Backpressure: RESP holds until rsp_ready; req_ready only in IDLE, no queueing.
module alu_op_issuer (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_shamt,
  output logic [4:0]  ctrl_ALUopcode,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  output logic [4:0]  ctrl_shiftamt,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_overflow,
  output logic        rsp_err
);

  localparam logic [4:0] OPC_ADD = 5'b00000;
  localparam logic [4:0] OPC_SUB = 5'b00001;
  localparam logic [4:0] OPC_AND = 5'b00010;
  localparam logic [4:0] OPC_OR  = 5'b00011;
  localparam logic [4:0] OPC_SLL = 5'b00100;
  localparam logic [4:0] OPC_SRA = 5'b00101;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t     state;
  logic       ovf_en;
  logic       err_q;
  logic [4:0] sel_opc;
  logic       sel_shift;
  logic       sel_ovf;
  logic       req_bad;

  // Lowest set bit wins; an empty op falls back to ADD.
  function automatic logic [4:0] encode_op(input logic [5:0] op);
    if      (op[0]) encode_op = OPC_ADD;
    else if (op[1]) encode_op = OPC_SUB;
    else if (op[2]) encode_op = OPC_AND;
    else if (op[3]) encode_op = OPC_OR;
    else if (op[4]) encode_op = OPC_SLL;
    else if (op[5]) encode_op = OPC_SRA;
    else            encode_op = OPC_ADD;
  endfunction

  always_comb begin
    sel_opc   = encode_op(req_op);
    sel_shift = (sel_opc == OPC_SLL) || (sel_opc == OPC_SRA);
    sel_ovf   = (sel_opc == OPC_ADD) || (sel_opc == OPC_SUB);
`ifdef ALU_OP_ISSUER_ERR_EN
    req_bad   = !((req_op != 6'd0) && ((req_op & (req_op - 6'd1)) == 6'd0));
`else
    req_bad   = 1'b0;
`endif
  end

  assign rsp_err = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_data       <= 32'd0;
      rsp_overflow   <= 1'b0;
      err_q          <= 1'b0;
      ovf_en         <= 1'b0;
      ctrl_ALUopcode <= OPC_ADD;
      data_operandA  <= 32'd0;
      data_operandB  <= 32'd0;
      ctrl_shiftamt  <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (req_bad) begin
              // Rejected ops bypass the ALU entirely; its ports stay parked at 0.
              state        <= RESP;
              rsp_valid    <= 1'b1;
              rsp_data     <= 32'd0;
              rsp_overflow <= 1'b0;
              err_q        <= 1'b1;
            end else begin
              state          <= ISSUE;
              err_q          <= 1'b0;
              ovf_en         <= sel_ovf;
              ctrl_ALUopcode <= sel_opc;
              data_operandA  <= req_a;
              data_operandB  <= req_b;
              ctrl_shiftamt  <= sel_shift ? req_shamt : 5'd0;
            end
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          state          <= RESP;
          rsp_valid      <= 1'b1;
          rsp_data       <= alu_result;
          rsp_overflow   <= alu_overflow & ovf_en;
          ctrl_ALUopcode <= OPC_ADD;
          data_operandA  <= 32'd0;
          data_operandB  <= 32'd0;
          ctrl_shiftamt  <= 5'd0;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
